// File: rtl/bw_arb_pkg.sv
// bw_arb_pkg: shared widths, output FSM states and ID-width helper for bw_mult_arbiter
package bw_arb_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 8;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/baugh_wooley_multiplier.sv
// baugh_wooley_multiplier: combinational 4x4 signed multiplier, Baugh-Wooley partial-product array
module baugh_wooley_multiplier (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);
  // Sign-row terms are inverted; constant 1s at bits 4 and 7 correct the result
  always_comb begin
    z = 8'h90;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        z = z + ({7'b0, ((i == 3) != (j == 3)) ^ (x[i] & y[j])} << (i + j));
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wrap-around
module rr_arbiter
  import bw_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);
  logic [ID_W:0] s;
  logic hit;
  always_comb begin
    grant = '0;
    hit = 1'b0;
    s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (ID_W+1)'(k);
      s = (s >= (ID_W+1)'(NUM_REQ)) ? s - (ID_W+1)'(NUM_REQ) : s;
      if (enable && !hit && req[s[ID_W-1:0]]) begin
        grant[s[ID_W-1:0]] = 1'b1;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bw_mult_arbiter.sv
// bw_mult_arbiter: round-robin sharing of one 4x4 signed multiplier with a registered response slot
// Optional BW_ARB_CHK_EN adds a sticky err flag comparing the multiplier against a reference product.
module bw_mult_arbiter
  import bw_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_x,
  input  logic [OP_W*NUM_REQ-1:0]   req_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [PROD_W-1:0]         rsp_z,
  output logic [ID_W-1:0]           rsp_id
`ifdef BW_ARB_CHK_EN
  , output logic                    err
`endif
);
  state_t state, state_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] ptr, gidx;
  logic [OP_W-1:0] x, y;
  logic [PROD_W-1:0] prod;
  logic free, any;
  assign rsp_valid = (state == FULL);
  assign free = !rsp_valid || rsp_ready;
  assign any = |grant;
  assign req_ready = grant;
  // rst_n gates the enable so no grant is offered while reset is held
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .enable(free && rst_n),
    .grant(grant)
  );
  always_comb begin
    gidx = '0;
    x = '0;
    y = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        gidx = gidx | ID_W'(i);
        x = x | req_x[OP_W*i +: OP_W];
        y = y | req_y[OP_W*i +: OP_W];
      end
  end
  baugh_wooley_multiplier u_mul (.x(x), .y(y), .z(prod));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = any ? FULL : (rsp_ready ? EMPTY : state);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_z <= '0;
      rsp_id <= '0;
      ptr <= '0;
    end else if (any) begin
      rsp_z <= prod;
      rsp_id <= gidx;
      ptr <= (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end
`ifdef BW_ARB_CHK_EN
  logic [PROD_W-1:0] chk_p;
  assign chk_p = $signed({{OP_W{x[OP_W-1]}}, x}) * $signed({{OP_W{y[OP_W-1]}}, y});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (any && prod != chk_p) err <= 1'b1;
`endif
endmodule

// File: tb/tb_bw_mult_arbiter.sv
// tb_bw_mult_arbiter: directed and randomized checks of bw_mult_arbiter against a transaction-level model
module tb_bw_mult_arbiter;
  logic clk = 1'b0, rst_n;
  logic [3:0] req_valid, req_ready;
  logic [15:0] req_x, req_y;
  logic rsp_valid, rsp_ready;
  logic [7:0] rsp_z;
  logic [1:0] rsp_id;
`ifdef BW_ARB_CHK_EN
  logic err;
`endif
  int total = 0, bad = 0;
  int m_ptr;
  bit m_v;
  logic [7:0] m_z;
  int m_id;
  always #5 clk = ~clk;
  bw_mult_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id)
`ifdef BW_ARB_CHK_EN
    , .err(err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // One clock: drive at posedge+1, check at posedge+3, advance model at the edge
  task automatic cycle(input logic [3:0] v, input logic [15:0] xs, input logic [15:0] ys,
                       input logic rr, output int g, output logic [3:0] got);
    int a, b, idx;
    req_valid = v; req_x = xs; req_y = ys; rsp_ready = rr;
    #2;
    g = -1;
    if (!m_v || rr)
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && v[idx]) g = idx;
      end
    got = req_ready;
    chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("rsp_valid", rsp_valid, m_v);
    if (m_v) begin
      chk("rsp_z", rsp_z, m_z);
      chk("rsp_id", rsp_id, m_id);
    end
    @(posedge clk); #1;
    if (g >= 0) begin
      a = $signed(xs[4*g +: 4]);
      b = $signed(ys[4*g +: 4]);
      m_v = 1; m_z = 8'(a * b); m_id = g; m_ptr = (g + 1) % 4;
    end else if (rr) m_v = 0;
  endtask
  initial begin
    int g, c0, c2;
    logic [3:0] got;
    bit pv[4];
    logic [3:0] px[4], py[4], v;
    logic [15:0] xs, ys;
    rst_n = 1'b0; req_valid = '1; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    m_v = 0; m_ptr = 0; m_z = 0; m_id = 0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_z", rsp_z, 0);
    chk("rst_id", rsp_id, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(4'b0001, 16'h0008, 16'h0008, 1, g, got);
    chk("z_m8m8", rsp_z, 8'h40);
    cycle(4'b0100, 16'h0700, 16'h0800, 1, g, got);
    chk("z_7m8", rsp_z, 8'hC8);
    chk("id_2", rsp_id, 2);
    cycle(4'b0100, 16'h0F00, 16'h0F00, 1, g, got);
    chk("z_m1m1", rsp_z, 8'h01);
    for (int k = 0; k < 6; k++) cycle(4'b1111, 16'h4321, 16'hF8A7, 1, g, got);
    cycle(4'b0010, 16'h0030, 16'h0070, 1, g, got);
    chk("z_15", rsp_z, 8'h15);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1111, 16'h5555, 16'h3333, 0, g, got);
      chk("hold_z", rsp_z, 8'h15);
      chk("hold_id", rsp_id, 1);
    end
    cycle(4'b1111, 16'h5555, 16'h3333, 1, g, got);
    chk("bp_release", got, 4'b0100);
    c0 = 0; c2 = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(4'b0101, 16'h0201, 16'h0603, 1, g, got);
      c0 += int'(got[0]); c2 += int'(got[2]);
    end
    chk("fair0", c0, 3);
    chk("fair2", c2, 3);
    for (int i = 0; i < 4; i++) pv[i] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; px[i] = 4'($urandom); py[i] = 4'($urandom);
        end
      for (int i = 0; i < 4; i++) begin
        v[i] = pv[i]; xs[4*i +: 4] = px[i]; ys[4*i +: 4] = py[i];
      end
      cycle(v, xs, ys, $urandom_range(0, 3) != 0, g, got);
      if (g >= 0) pv[g] = 0;
    end
    cycle(4'b1111, 16'h1111, 16'h2222, 0, g, got);
    chk("pre_rst_full", rsp_valid, 1);
    req_valid = 4'b1100; rsp_ready = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_z", rsp_z, 0);
    chk("arst_id", rsp_id, 0);
    chk("arst_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; m_v = 0; m_ptr = 0;
    cycle(4'b1100, 16'h3000, 16'h0500, 1, g, got);
    chk("post_rst_grant", got, 4'b0100);
    cycle(4'b0000, 16'h0000, 16'h0000, 1, g, got);
`ifdef BW_ARB_CHK_EN
    chk("err", err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
